// File: rtl/ibex_mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the fetch and LSU interfaces.
// Owner is locked until granted; an in-order ID FIFO steers each response back.
module ibex_mem_port_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned CntW = 3;
  localparam int unsigned PtrW = 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD_I = 2'd1;
  localparam logic [1:0] HOLD_D = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic            r_rr_data;
  logic [3:0]      r_fifo;
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_proto_err;

  logic w_fresh_d;
  logic w_own_d;
  logic w_sel_valid;
  logic w_full;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // r_rr_data=1 means the data port wins the next tie
  always_comb begin
    w_fresh_d    = 1'b0;
    w_own_d      = 1'b0;
    w_sel_valid  = 1'b0;
    w_full       = 1'b0;
    w_req        = 1'b0;
    w_push       = 1'b0;
    w_state_next = IDLE;

    if (DataPriority) w_fresh_d = data_req_i;
    else              w_fresh_d = data_req_i & (~instr_req_i | r_rr_data);

    case (r_state)
      HOLD_I:  w_own_d = instr_req_i ? 1'b0 : w_fresh_d;
      HOLD_D:  w_own_d = data_req_i  ? 1'b1 : w_fresh_d;
      default: w_own_d = w_fresh_d;
    endcase

    w_sel_valid = w_own_d ? data_req_i : instr_req_i;
    w_full      = (r_count >= CntW'(MaxOutstanding));
    w_req       = w_sel_valid & ~w_full;
    w_push      = w_req & mem_gnt_i;

    if (w_sel_valid && !w_push) w_state_next = w_own_d ? HOLD_D : HOLD_I;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_pop  = mem_rvalid_i & (r_count != '0);
  assign w_head = r_fifo[r_rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_data   <= 1'b0;
      r_fifo      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_own_d;
        r_wptr         <= ptr_inc(r_wptr);
        r_rr_data      <= ~w_own_d;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      if (mem_rvalid_i && (r_count == '0)) r_proto_err <= 1'b1;
    end
  end

  assign mem_req_o   = w_req;
  assign instr_gnt_o = w_push & ~w_own_d;
  assign data_gnt_o  = w_push &  w_own_d;

  // Fetches are always full-word reads; idle bus fields stay zero
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_sel_valid) begin
      if (w_own_d) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_rvalid_o = w_pop & ~w_head;
  assign data_rvalid_o  = w_pop &  w_head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign outstanding_o  = r_count;
  assign protocol_err_o = r_proto_err;

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Directed bench for ibex_mem_port_arbiter: round-robin instance plus a
// data-priority instance sharing the same stimulus.
module tb_ibex_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [2:0]  outstanding_o;
  logic        protocol_err_o;

  logic        dp_instr_gnt, dp_instr_rvalid, dp_instr_err;
  logic [31:0] dp_instr_rdata;
  logic        dp_data_gnt, dp_data_rvalid, dp_data_err;
  logic [31:0] dp_data_rdata;
  logic        dp_mem_req, dp_mem_we;
  logic [3:0]  dp_mem_be;
  logic [31:0] dp_mem_addr, dp_mem_wdata;
  logic [2:0]  dp_outstanding;
  logic        dp_protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ibex_mem_port_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  ibex_mem_port_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut_dp (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(dp_instr_gnt), .instr_rvalid_o(dp_instr_rvalid),
    .instr_rdata_o(dp_instr_rdata), .instr_err_o(dp_instr_err),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(dp_data_gnt), .data_rvalid_o(dp_data_rvalid),
    .data_rdata_o(dp_data_rdata), .data_err_o(dp_data_err),
    .mem_req_o(dp_mem_req), .mem_we_o(dp_mem_we), .mem_be_o(dp_mem_be),
    .mem_addr_o(dp_mem_addr), .mem_wdata_o(dp_mem_wdata),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(dp_outstanding), .protocol_err_o(dp_protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    mem_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    do_reset();

    // reset state
    mid();
    check("rst_instr_gnt", instr_gnt_o, 0);
    check("rst_data_gnt", data_gnt_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_perr", protocol_err_o, 0);

    // single fetch with immediate grant, response one cycle later
    tick();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h100;
    mem_gnt_i    = 1'b1;
    mid();
    check("t1_instr_gnt", instr_gnt_o, 1);
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_addr", mem_addr_o, 32'h100);
    check("t1_mem_be", mem_be_o, 4'hF);
    check("t1_mem_we", mem_we_o, 0);
    check("t1_mem_wdata", mem_wdata_o, 0);
    check("t1_data_rvalid0", data_rvalid_o, 0);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEADBEEF;
    mid();
    check("t1_outstanding", outstanding_o, 1);
    check("t1_instr_rvalid", instr_rvalid_o, 1);
    check("t1_instr_rdata", instr_rdata_o, 32'hDEADBEEF);
    check("t1_data_rvalid1", data_rvalid_o, 0);
    tick();
    idle_inputs();
    mid();
    check("t1_drained", outstanding_o, 0);
    check("t1_no_perr", protocol_err_o, 0);

    // round-robin alternation with pipelined responses
    do_reset();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h40;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h80;
    data_be_i    = 4'hF;
    mem_gnt_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = (k > 0);
      mem_rdata_i  = 32'(k);
      mid();
      check($sformatf("t2_ignt%0d", k), instr_gnt_o, (k % 2 == 0) ? 1 : 0);
      check($sformatf("t2_dgnt%0d", k), data_gnt_o, (k % 2 == 1) ? 1 : 0);
      check($sformatf("t2_addr%0d", k), mem_addr_o, (k % 2 == 0) ? 32'h40 : 32'h80);
      check($sformatf("t2_irv%0d", k), instr_rvalid_o, (k > 0 && (k % 2 == 1)) ? 1 : 0);
      check($sformatf("t2_drv%0d", k), data_rvalid_o, (k > 0 && (k % 2 == 0)) ? 1 : 0);
      check($sformatf("t2_out%0d", k), outstanding_o, (k > 0) ? 1 : 0);
      tick();
    end
    idle_inputs();
    mem_rvalid_i = 1'b1;
    mid();
    check("t2_last_drv", data_rvalid_o, 1);
    check("t2_last_irv", instr_rvalid_o, 0);
    tick();
    idle_inputs();
    mid();
    check("t2_drained", outstanding_o, 0);

    // data write stalled 3 cycles; late instr request must not steal the port
    do_reset();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0011;
    data_addr_i  = 32'h2000;
    data_wdata_i = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h300;
      end
      mem_gnt_i = (c == 3);
      mid();
      check($sformatf("t3_addr%0d", c), mem_addr_o, 32'h2000);
      check($sformatf("t3_dgnt%0d", c), data_gnt_o, (c == 3) ? 1 : 0);
      check($sformatf("t3_ignt%0d", c), instr_gnt_o, 0);
      tick();
    end
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    mid();
    check("t3_igrant", instr_gnt_o, 1);
    check("t3_iaddr", mem_addr_o, 32'h300);
    check("t3_iwe", mem_we_o, 0);
    check("t3_iwdata", mem_wdata_o, 0);
    tick();

    // FIFO full blocks the third fetch until a response has drained
    do_reset();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h500;
    mem_gnt_i    = 1'b1;
    mid();
    check("t4_g0", instr_gnt_o, 1);
    tick();
    mid();
    check("t4_g1", instr_gnt_o, 1);
    tick();
    mid();
    check("t4_blk_req", mem_req_o, 0);
    check("t4_blk_gnt", instr_gnt_o, 0);
    check("t4_blk_out", outstanding_o, 2);
    tick();
    mem_rvalid_i = 1'b1;
    mid();
    check("t4_pop_req", mem_req_o, 0);
    check("t4_pop_rv", instr_rvalid_o, 1);
    check("t4_pop_out", outstanding_o, 2);
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    check("t4_g2", instr_gnt_o, 1);
    check("t4_out1", outstanding_o, 1);
    tick();
    instr_req_i = 1'b0;
    mid();
    check("t4_out2", outstanding_o, 2);

    // fixed data priority
    do_reset();
    instr_req_i = 1'b1;
    data_req_i  = 1'b1;
    data_be_i   = 4'hF;
    mem_gnt_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = (k > 0);
      mid();
      check($sformatf("t5_dgnt%0d", k), dp_data_gnt, 1);
      check($sformatf("t5_ignt%0d", k), dp_instr_gnt, 0);
      check($sformatf("t5_drv%0d", k), dp_data_rvalid, (k > 0) ? 1 : 0);
      tick();
    end
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    mid();
    check("t5_igrant_after", dp_instr_gnt, 1);
    tick();

    // protocol error: stray rvalid, then reset mid-transaction
    do_reset();
    mem_rvalid_i = 1'b1;
    mid();
    check("t6_stray_irv", instr_rvalid_o, 0);
    check("t6_stray_drv", data_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    check("t6_perr_set", protocol_err_o, 1);
    instr_req_i = 1'b1;
    mem_gnt_i   = 1'b1;
    tick();
    tick();
    idle_inputs();
    mid();
    check("t6_out2", outstanding_o, 2);
    check("t6_perr_sticky", protocol_err_o, 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mid();
    check("t6_rst_out", outstanding_o, 0);
    check("t6_rst_perr", protocol_err_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mid();
      check($sformatf("t6_late_irv%0d", k), instr_rvalid_o, 0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    mid();
    check("t6_perr_again", protocol_err_o, 1);
    check("t6_out_final", outstanding_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_mem_port_arbiter.md
Name: ibex_mem_port_arbiter

Overview:
- Shares one memory bus port between the core's instruction-fetch and data (LSU) interfaces, using the core's req/gnt/rvalid protocol on all three sides.
- Sits between ibex_top and a single-ported RAM/bus in the simple system.
- Arbitrates requests, holds selection until grant, and tracks outstanding transactions in an in-order ID FIFO so each rvalid/rdata/err returns to the requester that issued it.

Parameters:
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (1..4); depth of the ID FIFO.
- DataPriority, 1'b0, 1 = data port has fixed priority; 0 = round-robin between ports.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- instr_err_o  out  1  fetch response error
- data_req_i  in  1  LSU request
- data_we_i  in  1  LSU write enable
- data_be_i  in  4  LSU byte enables
- data_addr_i  in  32  LSU address
- data_wdata_i  in  32  LSU write data
- data_gnt_o  out  1  LSU grant
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  32  LSU response data
- data_err_o  out  1  LSU response error
- mem_req_o  out  1  downstream request
- mem_we_o  out  1  downstream write enable (0 for fetch)
- mem_be_o  out  4  downstream byte enables (4'hF for fetch)
- mem_addr_o  out  32  downstream address
- mem_wdata_o  out  32  downstream write data (0 for fetch)
- mem_gnt_i  in  1  downstream grant
- mem_rvalid_i  in  1  downstream response valid
- mem_rdata_i  in  32  downstream response data
- mem_err_i  in  1  downstream response error
- outstanding_o  out  3  current ID FIFO occupancy
- protocol_err_o  out  1  sticky: rvalid received with empty FIFO

Behaviour:
- Reset, sampled on rising clk_i when rst_i=1: FSM=IDLE, FIFO empty, RR pointer=instr, protocol_err_o=0. Hence all gnt/rvalid/mem_req_o are 0 and outstanding_o=0.
- FSM states:
  - IDLE: no request presented.
  - HOLD_I / HOLD_D: a request is presented and the owner is locked.
- Selection in IDLE is combinational, the same cycle as the request.
  - DataPriority=1: data wins.
  - DataPriority=0: on a tie, the port not granted last wins; a lone requester always wins.
- mem_req_o = selected req_i AND (count < MaxOutstanding). The mux drives mem_* from the owner; other fields stay 0.
- Grant is zero-latency:
  - owner gnt_o = mem_gnt_i AND mem_req_o.
  - The non-owner gnt_o is always 0.
- In a request cycle without mem_gnt_i, the FSM moves to HOLD_owner. The owner stays locked while its req is held, regardless of new requests on the other port.
- On a handshake (mem_req_o AND mem_gnt_i):
  - push the owner ID into the FIFO;
  - update the RR pointer;
  - go to IDLE.
  - Next-cycle arbitration starts fresh, so back-to-back grants of 1/cycle are possible.
- FIFO full (count==MaxOutstanding): mem_req_o=0 and the FSM holds. A pop in the same cycle does not unblock until the next cycle.
- Response routing is combinational, zero latency.
  - On mem_rvalid_i with a non-empty FIFO: pop the head; the head's port gets rvalid_o=1, rdata_o=mem_rdata_i, err_o=mem_err_i.
  - rdata/err of both ports mirror the mem_* inputs at all times; only rvalid is steered.
- Push and pop in the same cycle: count is unchanged and ordering is preserved.
- mem_rvalid_i with an empty FIFO: response dropped (no rvalid_o) and protocol_err_o set; it is cleared only by reset.
- Reset mid-transaction: the FIFO is cleared, so late responses to pre-reset requests are dropped and flag protocol_err_o.
- Count width 3 bits; the pointers wrap modulo MaxOutstanding.

Test Plan:
1. Single fetch to addr 0x100, mem_gnt_i=1 same cycle, rvalid 1 cycle later with rdata 0xDEADBEEF -> instr_gnt_o=1 in cycle 0, mem_be_o=4'hF, mem_we_o=0; instr_rvalid_o=1 with instr_rdata_o=0xDEADBEEF in cycle 1; data_rvalid_o=0 throughout.
2. Both ports request continuously, DataPriority=0, mem_gnt_i=1 every cycle, rvalid 1 cycle later each -> grants alternate I,D,I,D; responses route in the same order; outstanding_o never exceeds 1.
3. Data write (we=1, be=4'b0011, addr 0x2000, wdata 0x1234) with mem_gnt_i low for 3 cycles while instr_req_i rises in cycle 1 -> mem_addr_o stays 0x2000 all 4 cycles; data_gnt_o in cycle 3; instr granted in cycle 4.
4. MaxOutstanding=2, 3 fetches granted, no rvalid -> third request blocked (mem_req_o=0, outstanding_o=2); after one rvalid, the third is granted the following cycle.
5. DataPriority=1, both requesting, mem_gnt_i=1 -> data granted every cycle; instr never granted while data_req_i=1.
6. mem_rvalid_i pulsed with the FIFO empty, then 2 fetches outstanding, rst_i pulsed, then 2 rvalids -> protocol_err_o=1 after the first pulse; after reset outstanding_o=0 and protocol_err_o=0; both late rvalids are dropped and protocol_err_o=1 again.
